// File: rtl/de2_115_led_pio_blink.sv
// ---------------------------------------------------------------------------
// de2_115_led_pio_blink
//
// Avalon-MM output PIO driving the DE2-115 LEDs. Holds a WIDTH-bit DATA
// register with atomic SET / CLEAR / TOGGLE aliases, a per-bit blink enable
// and a programmable blink prescaler. A blinking bit shows its DATA value
// while the blink phase is 1 and is forced to 0 while the phase is 0.
//
// Register map (word address):
//   0 DATA      R/W  LED value, bits [WIDTH-1:0]
//   1 BLINK_EN  R/W  1 = bit blinks, 0 = bit static
//   2 SET       W    DATA |= writedata          (reads 0)
//   3 CLEAR     W    DATA &= ~writedata         (reads 0)
//   4 TOGGLE    W    DATA ^= writedata          (reads 0)
//   5 PERIOD    R/W  blink half-period minus 1, bits [PRESCALE_W-1:0]
//   6 STATUS    R    bit0 = current blink phase (writes ignored)
//   7 -              reads 0, writes ignored
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   3-bit word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   32-bit write data
//   readdata    out  32-bit read data, combinational, zero wait states
//   out_port    out  WIDTH-bit LED drive
// ---------------------------------------------------------------------------
module de2_115_led_pio_blink #(
    parameter int unsigned WIDTH          = 27,
    parameter logic [31:0] RESET_VALUE    = 32'd0,
    parameter int unsigned PRESCALE_W     = 24,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd12499999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_SET    = 3'd2;
    localparam logic [2:0] ADDR_CLEAR  = 3'd3;
    localparam logic [2:0] ADDR_TOGGLE = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam logic [WIDTH-1:0]      DATA_RST   = RESET_VALUE[WIDTH-1:0];
    localparam logic [PRESCALE_W-1:0] PERIOD_RST = DEFAULT_PERIOD[PRESCALE_W-1:0];

    // Architectural state
    logic [WIDTH-1:0]      data_q,     data_d;
    logic [WIDTH-1:0]      blink_en_q, blink_en_d;
    logic [PRESCALE_W-1:0] period_q,   period_d;
    logic [PRESCALE_W-1:0] cnt_q,      cnt_d;
    logic                  phase_q,    phase_d;

    // Bus decode helpers
    logic                  wr_s;
    logic                  period_wr_s;
    logic                  terminal_s;
    logic [WIDTH-1:0]      wdata_reg_s;
    logic [PRESCALE_W-1:0] wdata_period_s;

    // Bits above the register widths are deliberately dropped; this sink keeps
    // the whole write bus referenced.
    logic                  unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign period_wr_s    = wr_s & (address == ADDR_PERIOD);
    assign terminal_s     = (cnt_q == period_q);
    assign wdata_reg_s    = writedata[WIDTH-1:0];
    assign wdata_period_s = writedata[PRESCALE_W-1:0];
    assign unused_wdata_s = ^writedata;

    // Next-state for DATA: plain write plus the atomic read-modify-write aliases
    always_comb begin
        data_d = data_q;
        if (wr_s) begin
            case (address)
                ADDR_DATA:   data_d = wdata_reg_s;
                ADDR_SET:    data_d = data_q | wdata_reg_s;
                ADDR_CLEAR:  data_d = data_q & ~wdata_reg_s;
                ADDR_TOGGLE: data_d = data_q ^ wdata_reg_s;
                default:     data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Next-state for BLINK_EN
    always_comb begin
        blink_en_d = blink_en_q;
        if (wr_s && (address == ADDR_BLINK)) begin
            blink_en_d = wdata_reg_s;
        end else begin
            blink_en_d = blink_en_q;
        end
    end

    // Next-state for PERIOD
    always_comb begin
        period_d = period_q;
        if (period_wr_s) begin
            period_d = wdata_period_s;
        end else begin
            period_d = period_q;
        end
    end

    // Blink prescaler: a PERIOD write restarts the half-period with phase=1
    // and takes priority over a coincident terminal count, so a shorter new
    // PERIOD can never leave cnt stranded above it.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr_s) begin
            cnt_d   = {PRESCALE_W{1'b0}};
            phase_d = 1'b1;
        end else if (terminal_s) begin
            cnt_d   = {PRESCALE_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + PRESCALE_W'(1);
            phase_d = phase_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= DATA_RST;
            blink_en_q <= {WIDTH{1'b0}};
            period_q   <= PERIOD_RST;
            cnt_q      <= {PRESCALE_W{1'b0}};
            phase_q    <= 1'b1;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    // LED drive: blinking bits are blanked during the low phase. Driven only
    // from registers, so the pins never glitch with bus activity.
    always_comb begin
        out_port = data_q & ~(blink_en_q & {WIDTH{~phase_q}});
    end

    // Read mux: purely address-driven, zero wait states, not gated by chipselect
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_BLINK:  readdata = 32'(blink_en_q);
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_STATUS: readdata = {31'd0, phase_q};
            default:     readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_de2_115_led_pio_blink.sv
// ---------------------------------------------------------------------------
// Testbench for de2_115_led_pio_blink. Stimulus pushes expected values into a
// scoreboard queue; a monitor drains the queue on each falling clock edge (or
// on an explicit sample event) and compares against the DUT outputs.
// Instance 0: default parameters. Instance 1: WIDTH=8, PRESCALE_W=4,
// RESET_VALUE=0x81, DEFAULT_PERIOD=5.
// ---------------------------------------------------------------------------
module tb_de2_115_led_pio_blink;

    logic        clk = 1'b0;
    logic        reset_n, reset_n2;
    logic [2:0]  address, address2;
    logic        chipselect, chipselect2, write_n, write_n2;
    logic [31:0] writedata, writedata2, readdata, readdata2;
    logic [26:0] out_port;
    logic [7:0]  out_port2;

    always #5 clk = ~clk;

    de2_115_led_pio_blink u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    de2_115_led_pio_blink #(
        .WIDTH          (8),
        .RESET_VALUE    (32'h81),
        .PRESCALE_W     (4),
        .DEFAULT_PERIOD (32'd5)
    ) u_dut2 (
        .clk        (clk),
        .reset_n    (reset_n2),
        .address    (address2),
        .chipselect (chipselect2),
        .write_n    (write_n2),
        .writedata  (writedata2),
        .readdata   (readdata2),
        .out_port   (out_port2)
    );

    // kind: 0 = out_port, 1 = readdata, 2 = out_port2, 3 = readdata2
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    event  sample_ev;

    // Monitor: compare every pending expectation against the DUT
    always @(negedge clk or sample_ev) begin
        item_t       it;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.kind)
                0:       act = 32'(out_port);
                1:       act = readdata;
                2:       act = 32'(out_port2);
                3:       act = readdata2;
                default: act = 32'hxxxxxxxx;
            endcase
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] e, input string nm);
        item_t it;
        it.kind = kind;
        it.exp  = e;
        it.name = nm;
        sb_q.push_back(it);
    endtask

    task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
        if (sel == 0) begin
            chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        end else begin
            chipselect2 = 1'b1; write_n2 = 1'b0; address2 = a; writedata2 = d;
        end
        tick();
        chipselect  = 1'b0; write_n  = 1'b1;
        chipselect2 = 1'b0; write_n2 = 1'b1;
    endtask

    task automatic rd(input int sel, input logic [2:0] a, input logic [31:0] e, input string nm);
        if (sel == 0) address = a;
        else          address2 = a;
        push((sel == 0) ? 1 : 3, e, nm);
        tick();
    endtask

    initial begin
        bit ph;
        reset_n = 1'b0; reset_n2 = 1'b0;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        chipselect2 = 1'b0; write_n2 = 1'b1; address2 = 3'd0; writedata2 = 32'd0;

        // Reset state
        tick();
        push(0, 32'h0, "rst_out");
        tick();
        reset_n = 1'b1;
        rd(0, 3'd1, 32'h0, "rst_blink_en");
        rd(0, 3'd5, 32'd12499999, "rst_period");
        rd(0, 3'd0, 32'h0, "rst_data");
        rd(0, 3'd6, 32'h1, "rst_status");

        // DATA write and width masking
        wr(0, 3'd0, 32'h05A5A5A5);
        push(0, 32'h05A5A5A5, "data_out");
        rd(0, 3'd0, 32'h05A5A5A5, "data_rd");
        wr(0, 3'd0, 32'hFFFFFFFF);
        push(0, 32'h07FFFFFF, "data_all_out");
        rd(0, 3'd0, 32'h07FFFFFF, "data_all_rd");

        // Back-to-back SET / CLEAR / TOGGLE
        wr(0, 3'd0, 32'h0F0);
        wr(0, 3'd2, 32'h003);
        push(0, 32'h0F3, "set_out");
        wr(0, 3'd3, 32'h030);
        push(0, 32'h0C3, "clear_out");
        wr(0, 3'd4, 32'h101);
        push(0, 32'h1C2, "toggle_out");
        rd(0, 3'd2, 32'h0, "set_rd0");
        rd(0, 3'd3, 32'h0, "clear_rd0");
        rd(0, 3'd4, 32'h0, "toggle_rd0");
        rd(0, 3'd0, 32'h1C2, "rmw_data_rd");
        rd(0, 3'd7, 32'h0, "addr7_rd0");

        // PERIOD=3 blink on bit0, bit1 static
        wr(0, 3'd0, 32'h3);
        wr(0, 3'd1, 32'h1);
        wr(0, 3'd5, 32'd3);
        address = 3'd6;
        for (int i = 0; i < 16; i++) begin
            ph = (((i / 4) % 2) == 0);
            push(0, ph ? 32'h3 : 32'h2, $sformatf("blink3_out_%0d", i));
            push(1, ph ? 32'h1 : 32'h0, $sformatf("blink3_status_%0d", i));
            tick();
        end

        // PERIOD=0: toggle every cycle, then PERIOD=9 written on terminal count
        wr(0, 3'd0, 32'h0AB);
        wr(0, 3'd1, 32'hFFFFFFFF);
        wr(0, 3'd5, 32'd0);
        for (int i = 0; i < 6; i++) begin
            push(0, ((i % 2) == 0) ? 32'h0AB : 32'h0, $sformatf("blink0_out_%0d", i));
            tick();
        end
        wr(0, 3'd5, 32'd9);
        for (int j = 0; j < 12; j++) begin
            push(0, (j < 10) ? 32'h0AB : 32'h0, $sformatf("blink9_out_%0d", j));
            tick();
        end
        rd(0, 3'd5, 32'd9, "period9_rd");

        // Asynchronous reset mid-blink
        wr(0, 3'd5, 32'd3);
        wr(0, 3'd0, 32'h7);
        push(0, 32'h7, "pre_reset_out");
        ->sample_ev;
        #1;
        reset_n = 1'b0;
        #1;
        push(0, 32'h0, "async_rst_out");
        push(1, 32'h0, "async_rst_data_rd");
        ->sample_ev;
        #1;
        tick();
        tick();
        reset_n = 1'b1;
        rd(0, 3'd5, 32'd12499999, "post_rst_period");
        rd(0, 3'd1, 32'h0, "post_rst_blink_en");
        rd(0, 3'd6, 32'h1, "post_rst_status");

        // Small instance: reset value and first toggle after DEFAULT_PERIOD+1 edges
        push(2, 32'h81, "d2_rst_out");
        address2 = 3'd6;
        push(3, 32'h1, "d2_rst_status");
        tick();
        reset_n2 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            push(3, (k < 6) ? 32'h1 : 32'h0, $sformatf("d2_first_toggle_%0d", k));
        end
        tick();

        // Small instance: field truncation and ignored addresses
        wr(1, 3'd5, 32'h1F);
        rd(1, 3'd5, 32'hF, "d2_period_trunc");
        wr(1, 3'd0, 32'h1FF);
        rd(1, 3'd0, 32'hFF, "d2_data_trunc");
        wr(1, 3'd0, 32'h3C);
        wr(1, 3'd1, 32'h0F);
        wr(1, 3'd6, 32'hFFFFFFFF);
        wr(1, 3'd7, 32'hFFFFFFFF);
        rd(1, 3'd0, 32'h3C, "d2_data_kept");
        rd(1, 3'd1, 32'h0F, "d2_blink_kept");
        rd(1, 3'd5, 32'hF, "d2_period_kept");
        rd(1, 3'd7, 32'h0, "d2_addr7_rd0");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d items left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
